// File: rtl/switch_pkg.sv
// Shared switch definitions: payload geometry and the egress serializer FSM states.
package switch_pkg;
    localparam int PAYLOAD_W = 32;
    localparam int ADDR_W    = 4;
    localparam int NPORTS    = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/portout_serializer_if.sv
// Crossbar-to-egress payload handshake for one output port.
interface portout_serializer_if;
    import switch_pkg::*;

    logic                 in_vld;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_rdy;

    modport master (output in_vld, output in_payload, input in_rdy);
    modport slave  (input in_vld, input in_payload, output in_rdy);
endinterface

// File: rtl/portout_fifo.sv
// Small synchronous FIFO holding payloads waiting to be serialized.
module portout_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= din;
    end

    assign dout  = mem[rptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
endmodule

// File: rtl/portout_serializer.sv
// Egress stage: buffers routed payloads and shifts each out LSB-first with
// active-low frame/valid framing, one idle cycle between frames.
module portout_serializer
    import switch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    portout_serializer_if.slave  bus,
    output logic                 frame_o_n,
    output logic                 valid_o_n,
    output logic                 dout,
    output logic                 busy,
    output logic [7:0]           drop_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t               state, state_d;
    logic [PAYLOAD_W-1:0] shreg, fifo_dout;
    logic [4:0]           bitcnt;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full, fifo_empty;
    logic                 in_rdy, push, pop, drop;
    logic                 frame_d, valid_d, dout_d, busy_d;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
    assign in_rdy     = (fifo_count != DEPTH_C);
    assign bus.in_rdy = in_rdy;
    assign push       = bus.in_vld && in_rdy;
    assign drop       = bus.in_vld && fifo_full;

    portout_fifo #(.DEPTH(DEPTH), .WIDTH(PAYLOAD_W)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (bus.in_payload),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        frame_d = 1'b1;
        valid_d = 1'b1;
        dout_d  = 1'b0;
        busy_d  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                dout_d  = shreg[0];
                valid_d = 1'b0;
                frame_d = (bitcnt == 5'd31);
                busy_d  = 1'b1;
                if (bitcnt == 5'd31) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            bitcnt    <= '0;
            frame_o_n <= 1'b1;
            valid_o_n <= 1'b1;
            dout      <= 1'b0;
            busy      <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            frame_o_n <= frame_d;
            valid_o_n <= valid_d;
            dout      <= dout_d;
            busy      <= busy_d;
            if (pop) begin
                shreg  <= fifo_dout;
                bitcnt <= '0;
            end else if (state == SEND) begin
                shreg  <= {1'b0, shreg[PAYLOAD_W-1:1]};
                bitcnt <= bitcnt + 1'b1;
            end
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_portout_serializer.sv
// Directed bench for portout_serializer: framing, latency, ordering, drops and reset.
module tb_portout_serializer;
    import switch_pkg::*;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic       frame_o_n, valid_o_n, dout, busy;
    logic [7:0] drop_cnt;

    portout_serializer_if bus();

    portout_serializer #(.DEPTH(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .frame_o_n (frame_o_n),
        .valid_o_n (valid_o_n),
        .dout      (dout),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clock = ~clock;

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Wire monitor: reassembles frames, records start cycle and preceding idle gap.
    int          cyc = 0;
    logic [31:0] rx_q[$];
    int          gap_q[$];
    int          start_q[$];
    logic [5:0]  rx_bits = '0;
    logic [31:0] rx_sh = '0;
    int          idle_run = 0, proto_err = 0, vlow = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset_n) begin
            rx_bits  = '0;
            idle_run = 0;
            if (frame_o_n !== 1'b1 || valid_o_n !== 1'b1 || dout !== 1'b0 || busy !== 1'b0) proto_err++;
        end else if (valid_o_n === 1'b0) begin
            if (rx_bits == 6'd0) begin
                gap_q.push_back(idle_run);
                start_q.push_back(cyc);
            end
            idle_run = 0;
            vlow++;
            rx_sh[rx_bits[4:0]] = dout;
            if (frame_o_n !== (rx_bits == 6'd31) || busy !== 1'b1) proto_err++;
            if (rx_bits == 6'd31) begin
                rx_q.push_back(rx_sh);
                rx_bits = '0;
            end else begin
                rx_bits++;
            end
        end else begin
            if (frame_o_n !== 1'b1 || dout !== 1'b0 || busy !== 1'b0 || rx_bits != 6'd0) proto_err++;
            rx_bits = '0;
            idle_run++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic push1(input logic [31:0] p);
        bus.in_vld = 1'b1;
        bus.in_payload = p;
        @(posedge clock); #1;
        bus.in_vld = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n);
        int t = 0;
        while (rx_q.size() < n && t < 400) begin @(posedge clock); #1; t++; end
        chk(tag, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_busy(input string tag);
        int t = 0;
        while (busy !== 1'b1 && t < 20) begin @(posedge clock); #1; t++; end
        chk(tag, 32'(busy), 32'd1);
    endtask

    task automatic clear();
        rx_q.delete();
        gap_q.delete();
        start_q.delete();
        vlow = 0;
    endtask

    logic [31:0] pl [6];
    int          push_cyc;

    initial begin
        bus.in_vld = 1'b0;
        bus.in_payload = '0;
        #1 reset_n = 1'b0;
        #11;
        chk("rst_out",  32'({frame_o_n, valid_o_n, dout, busy}), 32'hC);
        chk("rst_rdy",  32'(bus.in_rdy), 32'd1);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        @(posedge clock); #1 reset_n = 1'b1;
        cycles(2);

        // Single frame, latency and length
        clear();
        bus.in_vld = 1'b1;
        bus.in_payload = 32'h8000_0001;
        @(posedge clock); #1;
        push_cyc = cyc;
        bus.in_vld = 1'b0;
        wait_rx("single_n", 1);
        chk("single_data", rx_q[0], 32'h8000_0001);
        chk("single_lat", 32'(start_q[0] - push_cyc), 32'd2);
        cycles(5);
        chk("single_vlow", 32'(vlow), 32'd32);

        // Back-to-back pushes
        clear();
        bus.in_vld = 1'b1;
        bus.in_payload = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        bus.in_payload = 32'h1234_5678;
        @(posedge clock); #1;
        bus.in_vld = 1'b0;
        wait_rx("b2b_n", 2);
        chk("b2b_d0", rx_q[0], 32'hDEAD_BEEF);
        chk("b2b_d1", rx_q[1], 32'h1234_5678);
        chk("b2b_gap", 32'(gap_q[1]), 32'd1);
        chk("b2b_vlow", 32'(vlow), 32'd64);

        // Fill and drop while a frame is sending
        clear();
        push1(32'h0000_00F0);
        wait_busy("fill_busy");
        for (int i = 0; i < 6; i++) begin
            pl[i] = 32'h1111_1111 * 32'(i + 1);
            bus.in_vld = 1'b1;
            bus.in_payload = pl[i];
            @(negedge clock);
            chk("fill_rdy", 32'(bus.in_rdy), (i < 4) ? 32'd1 : 32'd0);
            @(posedge clock); #1;
        end
        bus.in_vld = 1'b0;
        chk("fill_drop", 32'(drop_cnt), 32'd2);
        wait_rx("fill_n", 5);
        chk("fill_d0", rx_q[0], 32'h0000_00F0);
        for (int i = 0; i < 4; i++) chk("fill_order", rx_q[i+1], pl[i]);

        // Drop counter saturation
        clear();
        push1(32'hCAFE_0000);
        wait_busy("sat_busy");
        bus.in_vld = 1'b1;
        bus.in_payload = 32'h5A5A_5A5A;
        cycles(300);
        bus.in_vld = 1'b0;
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        reset_n = 1'b0;
        cycles(2);
        chk("sat_rst_drop", 32'(drop_cnt), 32'd0);
        reset_n = 1'b1;
        clear();
        cycles(40);
        chk("flush_vlow", 32'(vlow), 32'd0);

        // Reset in the middle of a frame
        clear();
        push1(32'hA5A5_0F0F);
        begin
            int t = 0;
            while (rx_bits != 6'd10 && t < 50) begin @(negedge clock); t++; end
        end
        chk("mid_bits", 32'(rx_sh[9:0]), 32'h30F);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        chk("mid_out", 32'({frame_o_n, valid_o_n, dout, busy}), 32'hC);
        chk("mid_rdy", 32'(bus.in_rdy), 32'd1);
        @(posedge clock); #1 reset_n = 1'b1;
        clear();
        cycles(60);
        chk("mid_noframe", 32'(vlow), 32'd0);

        // Push in the IDLE pop cycle, then top up to full
        clear();
        pl[0] = 32'h0102_0304; pl[1] = 32'hF0E0_D0C0; pl[2] = 32'h7777_0000;
        pl[3] = 32'h0000_8888; pl[4] = 32'h1357_9BDF;
        for (int i = 0; i < 5; i++) begin
            bus.in_vld = 1'b1;
            bus.in_payload = pl[i];
            if (i == 4) begin
                @(negedge clock);
                chk("sim_rdy3", 32'(bus.in_rdy), 32'd1);
            end
            @(posedge clock); #1;
        end
        bus.in_vld = 1'b0;
        @(negedge clock);
        chk("sim_full", 32'(bus.in_rdy), 32'd0);
        wait_rx("sim_n", 5);
        for (int i = 0; i < 5; i++) chk("sim_order", rx_q[i], pl[i]);
        for (int i = 1; i < 5; i++) chk("sim_gap", 32'(gap_q[i]), 32'd1);
        chk("sim_drop", 32'(drop_cnt), 32'd0);

        chk("proto", 32'(proto_err), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
